// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: fixed-length SRAM access sequencer for the MEM stage; ~ready freezes the pipeline.
module mem_stage_sram_ctrl #(
    parameter int ACCESS_CYCLES = 5,
    parameter int ADDR_BASE     = 1024,
    parameter int ADDR_W        = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [31:0]       SRAM_DQ_out,
    output logic              SRAM_DQ_oe,
    input  logic [31:0]       SRAM_DQ_in,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);
    state_t state, nxt;
    logic [3:0] cnt;
    logic is_wr, nxt_wr, req, last;
    assign req  = MEM_R_EN | MEM_W_EN;
    assign last = cnt == LAST;
    always_comb begin
        nxt    = state == IDLE ? (req ? BUSY : IDLE) : state == BUSY ? (last ? DONE : BUSY) : IDLE;
        nxt_wr = (state == IDLE && req) ? MEM_W_EN : is_wr;
        ready  = state == DONE || (state == IDLE && !req);
    end
    // strobes are registered from the next-state decode so they align with BUSY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_wr       <= 1'b0;
            rdata       <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_WE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_DQ_oe  <= 1'b0;
        end else begin
            state      <= nxt;
            is_wr      <= nxt_wr;
            SRAM_WE_N  <= !(nxt == BUSY && nxt_wr);
            SRAM_OE_N  <= !(nxt == BUSY && !nxt_wr);
            SRAM_DQ_oe <= nxt == BUSY && nxt_wr;
            if (state == IDLE && req) begin
                cnt         <= '0;
                SRAM_ADDR   <= ADDR_W'((address - 32'(ADDR_BASE)) >> 2);
                SRAM_DQ_out <= wdata;
            end else if (state == BUSY && !last) begin
                cnt <= cnt + 4'd1;
            end
            if (state == BUSY && last && !is_wr) rdata <= SRAM_DQ_in;
        end
    end
endmodule

// File: doc/mem_stage_sram_ctrl.md
# mem_stage_sram_ctrl

Multi-cycle SRAM access controller for the MEM stage of the pipelined MIPS core. It takes the memory read/write enables, address and store value held in the EX/MEM pipeline register, and sequences a fixed-length access on an external word-wide SRAM. It returns load data and a `ready` flag, and the core uses `~ready` as the `freeze` input of all pipeline registers.

## Interface
- `ACCESS_CYCLES`, default 5: number of cycles the SRAM strobe is held per access, legal range 1..15.
- `ADDR_BASE`, default 1024: byte address that maps to SRAM word 0.
- `ADDR_W`, default 17: SRAM word-address width.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `MEM_R_EN`  in  1: load request, from the EX/MEM register.
- `MEM_W_EN`  in  1: store request, from the EX/MEM register.
- `address`  in  32: byte address (ALU result).
- `wdata`  in  32: store value.
- `rdata`  out  32: last completed load data.
- `ready`  out  1: high when the pipeline may advance.
- `SRAM_ADDR`  out  ADDR_W: SRAM word address.
- `SRAM_DQ_out`  out  32: write data to SRAM.
- `SRAM_DQ_oe`  out  1: data-bus output enable.
- `SRAM_DQ_in`  in  32: read data from SRAM.
- `SRAM_WE_N`  out  1: write strobe, active-low.
- `SRAM_OE_N`  out  1: read strobe, active-low.

## Operation
- The request is `req = MEM_R_EN | MEM_W_EN`. If both enables are high, the access is a write.
- The FSM has three states: IDLE, BUSY and DONE. The counter `cnt` is 4 bits wide.
- **IDLE:**
  - On `req`, latch the access type, `SRAM_ADDR <= (address - ADDR_BASE) >> 2` truncated to ADDR_W bits, and `SRAM_DQ_out <= wdata`.
  - On the same edge, set `cnt <= 0` and go to BUSY.
  - Bits [1:0] of `address` are ignored. There is no range check; subtraction wraps mod 2^32.
- **BUSY:**
  - For a write: `SRAM_WE_N = 0` and `SRAM_DQ_oe = 1`.
  - For a read: `SRAM_OE_N = 0`.
  - While `cnt < ACCESS_CYCLES-1`, increment `cnt`.
  - When `cnt == ACCESS_CYCLES-1`:
    - On a read, capture `rdata <= SRAM_DQ_in`.
    - Go to DONE.
- **DONE:**
  - All strobes are inactive. `ready = 1` for exactly one cycle, so the EX/MEM register advances.
  - Go to IDLE unconditionally; inputs are ignored in this state.
- **ready (combinational):** `ready = (state==DONE) | (state==IDLE & ~req)`. A new request in IDLE pulls `ready` low in the same cycle.
- `rdata` holds its value until the next read completes. Writes never change `rdata`.
- `SRAM_ADDR` and `SRAM_DQ_out` hold their latched values through BUSY and DONE, and after the access.
- Strobes and `SRAM_DQ_oe` are registered outputs decoded from state, so they are glitch-free.
- **Reset values:**
  - state = IDLE, `cnt` = 0, `rdata` = 0, `SRAM_ADDR` = 0, `SRAM_DQ_out` = 0.
  - `SRAM_WE_N` = 1, `SRAM_OE_N` = 1, `SRAM_DQ_oe` = 0.
  - `ready` = `~req`.
- **Reset mid-access:** the access is aborted immediately (asynchronously). Strobes deassert in the same instant, with no partial `rdata` update. After `rst` falls, a still-asserted request starts a fresh access.

## Timing
- Cycle 0 is the first cycle `req` is seen in IDLE; `ready` = 0 in that cycle.
- Cycles 1..ACCESS_CYCLES are BUSY: strobe low, `ready` = 0.
- For reads, `SRAM_DQ_in` is sampled on the clock edge ending cycle ACCESS_CYCLES.
- Cycle ACCESS_CYCLES+1 is DONE: `ready` = 1, and `rdata` is valid from the start of this cycle.
- Total per access: ACCESS_CYCLES+2 cycles, with `ready` low for ACCESS_CYCLES+1 cycles.
- Back-to-back requests: IDLE is re-entered in cycle ACCESS_CYCLES+2, and the next request is seen there. There is a minimum of one DONE cycle between strobe windows.
- With ACCESS_CYCLES = 1: BUSY lasts 1 cycle, and the total is 3 cycles.
- In IDLE with no request, `ready` = 1 continuously and the pipeline is not stalled.

## Test plan
- **Reset idle:** hold `rst` with `req` = 0, then release. Required: `ready` = 1, both strobes = 1, `SRAM_DQ_oe` = 0, `rdata` = 0, `SRAM_ADDR` = 0.
- **Write:** `MEM_W_EN` = 1, `address` = 1028, `wdata` = 0xDEADBEEF, defaults. Required:
  - `SRAM_ADDR` = 1.
  - `SRAM_WE_N` = 0 and `SRAM_DQ_oe` = 1 in cycles 1-5, with `SRAM_DQ_out` = 0xDEADBEEF.
  - `ready` = 0 in cycles 0-5 and 1 in cycle 6.
  - `rdata` unchanged.
- **Read:** model returns 0xDEADBEEF for word 1. `MEM_R_EN` = 1, `address` = 1028. Required:
  - `SRAM_OE_N` = 0 in cycles 1-5, `SRAM_WE_N` = 1 throughout.
  - `rdata` = 0xDEADBEEF and `ready` = 1 in cycle 6.
- **Both enables and misalignment:** `MEM_R_EN` = `MEM_W_EN` = 1, `address` = 1031. Required: write performed, `SRAM_ADDR` = 1, `SRAM_OE_N` stays 1.
- **Back-to-back:** read held through DONE, then a second read to address 1032 presented. Required:
  - Exactly one `ready` = 1 cycle (cycle 6).
  - The second access latches `SRAM_ADDR` = 2 in cycle 7.
  - The strobe is high in cycle 6.
- **Reset mid-access:** assert `rst` in cycle 3 of a write. Required: `SRAM_WE_N` = 1 and `SRAM_DQ_oe` = 0 immediately, and state = IDLE. After release with `MEM_W_EN` still 1, a full 7-cycle write repeats.
